// File: rtl/apb_led_ctrl.sv
// apb_led_ctrl: APB slave driving a bank of registered LED outputs.
// Registers (word offsets): 0x0 CTRL, 0x4 LED_VAL, 0x8 PRESCALE, 0xC STATUS.
// Every transfer moves through IDLE -> SETUP -> WAIT -> ACCESS. pready is
// high only in ACCESS, and writes commit only at the end of that cycle.
// Optional feature macro: LED_BLINK_EN adds the blink prescaler, the blink
// phase, CTRL.BLINK and the PRESCALE/STATUS contents. Without the macro,
// led_o = EN ? LED_VAL : 0.
// Handshake: a transfer is one setup beat (psel=1, penable=0) followed by
// access beats (psel=1, penable=1) held until pready=1. Dropping psel before
// ACCESS aborts the transfer, and an aborted transfer changes nothing.
module apb_led_ctrl #(
  parameter int PADDR_WIDTH = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int LED_NUM     = 8,
  parameter int PRESC_WIDTH = 16
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [PADDR_WIDTH-1:0]  paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic [LED_NUM-1:0]      led_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACCESS = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                  r_en;
  logic [LED_NUM-1:0]    r_led_val;
  logic [LED_NUM-1:0]    r_led_o;
  logic                  w_blink;
  logic                  w_addr_hit;
  logic                  w_commit;
  logic                  w_wr_ctrl;
  logic                  w_wr_led;
  logic [DATA_WIDTH-1:0] w_reg_rd;
  logic [DATA_WIDTH-1:0] w_merge;
  logic [LED_NUM-1:0]    w_led_nxt;
  logic                  w_unused_ok;

`ifdef LED_BLINK_EN
  logic                   r_blink;
  logic [PRESC_WIDTH-1:0] r_presc;
  logic [PRESC_WIDTH-1:0] r_cnt;
  logic                   r_phase;
  logic                   w_wr_presc;
  assign w_blink = r_blink;
`else
  assign w_blink = 1'b0;
`endif

  // State register; reset also abandons any transfer in flight.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; losing psel before ACCESS aborts the transfer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (psel && !penable) w_state_nxt = ST_SETUP;
      ST_SETUP:  if (!psel)            w_state_nxt = ST_IDLE;
                 else if (penable)     w_state_nxt = ST_WAIT;
      ST_WAIT:   if (!psel)            w_state_nxt = ST_IDLE;
                 else                  w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (psel && !penable) w_state_nxt = ST_SETUP;
                 else                  w_state_nxt = ST_IDLE;
      default:                         w_state_nxt = ST_IDLE;
    endcase
  end

  assign pready     = (r_state == ST_ACCESS);
  assign w_addr_hit = (paddr[PADDR_WIDTH-1:4] == '0);
  assign w_commit   = pready && psel && pwrite && w_addr_hit;
  assign w_wr_ctrl  = w_commit && (paddr[3:2] == 2'd0);
  assign w_wr_led   = w_commit && (paddr[3:2] == 2'd1);
`ifdef LED_BLINK_EN
  assign w_wr_presc = w_commit && (paddr[3:2] == 2'd2);
`endif

  // Register read mux; unmapped offsets and absent fields read as zero.
  always_comb begin
    w_reg_rd = '0;
    if (w_addr_hit) begin
      case (paddr[3:2])
        2'd0: w_reg_rd = DATA_WIDTH'({w_blink, r_en});
        2'd1: w_reg_rd = DATA_WIDTH'(r_led_val);
`ifdef LED_BLINK_EN
        2'd2: w_reg_rd = DATA_WIDTH'(r_presc);
        2'd3: w_reg_rd = DATA_WIDTH'(r_phase) | (DATA_WIDTH'(r_cnt) << 16);
`endif
        default: w_reg_rd = '0;
      endcase
    end
  end

  assign prdata = (pready && !pwrite) ? w_reg_rd : '0;

  // Byte-lane merge: strobed lanes take pwdata, others keep the current value.
  always_comb begin
    w_merge = w_reg_rd;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      if (pstrb[i]) w_merge[8*i +: 8] = pwdata[8*i +: 8];
    end
  end

  // CTRL and LED_VAL registers, written only at the end of ACCESS.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_en      <= 1'b0;
      r_led_val <= '0;
    end else begin
      if (w_wr_ctrl) r_en      <= w_merge[0];
      if (w_wr_led)  r_led_val <= w_merge[LED_NUM-1:0];
    end
  end

`ifdef LED_BLINK_EN
  // BLINK bit and PRESCALE terminal count.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_blink <= 1'b0;
      r_presc <= '0;
    end else begin
      if (w_wr_ctrl)  r_blink <= w_merge[1];
      if (w_wr_presc) r_presc <= w_merge[PRESC_WIDTH-1:0];
    end
  end

  // Prescaler and phase; a PRESCALE write restarts the count and beats a wrap.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_wr_presc) begin
      r_cnt   <= '0;
    end else if (!(r_en && r_blink)) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == r_presc) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + PRESC_WIDTH'(1);
    end
  end

  // LED pattern gated by enable and, while blinking, by the phase.
  always_comb begin
    w_led_nxt = '0;
    if (r_en && (!r_blink || r_phase)) w_led_nxt = r_led_val;
  end
`else
  // LED pattern gated by enable only.
  always_comb begin
    w_led_nxt = '0;
    if (r_en) w_led_nxt = r_led_val;
  end
`endif

  // Registered LED drive, one cycle behind the register state.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_led_o <= '0;
    else          r_led_o <= w_led_nxt;
  end

  assign led_o = r_led_o;

  // Byte offset bits and merged lanes beyond the implemented fields.
  assign w_unused_ok = ^{paddr[1:0], w_merge};

endmodule
